// File: rtl/field_packer_stream.sv
// Packs NUM_FIELDS fields plus a constant tail into one frame and streams it MSB-first
// as OUT_W-bit words over valid/ready. Define FIELD_PACKER_PARITY_EN to add out_parity.
module field_packer_stream #(
  parameter int unsigned FIELD_W    = 5,
  parameter int unsigned NUM_FIELDS = 6,
  parameter int unsigned PAD_W      = 2,
  parameter logic [31:0] PAD_VAL    = 32'h3,
  parameter int unsigned OUT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_last
`ifdef FIELD_PACKER_PARITY_EN
  ,
  output logic                          out_parity
`endif
);

  localparam int unsigned IN_W      = NUM_FIELDS * FIELD_W;
  localparam int unsigned TOTAL_W   = IN_W + PAD_W;
  localparam int unsigned NUM_WORDS = TOTAL_W / OUT_W;
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  if (TOTAL_W % OUT_W != 0) begin : g_width_check
    $error("field_packer_stream: TOTAL_W (%0d) must be a multiple of OUT_W (%0d)",
           TOTAL_W, OUT_W);
  end

  logic [TOTAL_W-1:0] frame_in;

  if (PAD_W > 0) begin : g_pad
    assign frame_in = {in_data, PAD_VAL[PAD_W-1:0]};
  end else begin : g_no_pad
    assign frame_in = in_data;
  end

  state_t             state;
  logic [TOTAL_W-1:0] frame;
  logic [IDX_W-1:0]   word_idx;
  logic               accept;
  logic               advance;

  // in_ready looks at out_ready so a new frame can load in the cycle the last word leaves.
  assign in_ready = (state == IDLE) || ((state == SEND) && out_ready && out_last);
  assign accept   = in_valid && in_ready;
  assign advance  = out_valid && out_ready && !out_last;

  // The frame register keeps the words not yet presented, MSB-aligned, so the next
  // word is always its top slice and no wide index mux is needed.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame     <= '0;
      word_idx  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      state     <= SEND;
      out_valid <= 1'b1;
      out_data  <= frame_in[TOTAL_W-1 -: OUT_W];
      frame     <= frame_in << OUT_W;
      word_idx  <= '0;
      out_last  <= (NUM_WORDS == 1);
    end else if (advance) begin
      out_data  <= frame[TOTAL_W-1 -: OUT_W];
      frame     <= frame << OUT_W;
      word_idx  <= word_idx + 1'b1;
      out_last  <= ((word_idx + 1'b1) == LAST_IDX);
    end else if (out_valid && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

`ifdef FIELD_PACKER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (accept) begin
      out_parity <= ^frame_in[TOTAL_W-1 -: OUT_W];
    end else if (advance) begin
      out_parity <= ^frame[TOTAL_W-1 -: OUT_W];
    end
  end
`endif

endmodule
